// File: rtl/alu_pkg.sv
// Shared definitions for the ALU result path: op codes, data width and the
// buffered entry record.
package alu_pkg;

    localparam int unsigned ALU_W = 4;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_NOT = 3'b101;
    localparam logic [2:0] OP_SHL = 3'b110;
    localparam logic [2:0] OP_SHR = 3'b111;

    typedef struct packed {
        logic [2:0]       sel;
        logic             carry;
        logic             zero;
        logic [ALU_W-1:0] result;
    } alu_entry_t;

    localparam int unsigned ENTRY_W = $bits(alu_entry_t);

endpackage

// File: rtl/alu_fifo_mem.sv
// DEPTH-entry register array holding ALU result records; one write port and
// one combinational read port. Contents are not reset.
module alu_fifo_mem
    import alu_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [PTR_W-1:0] wr_addr,
    input  alu_entry_t       wr_data,
    input  logic [PTR_W-1:0] rd_addr,
    output alu_entry_t       rd_data
);

    alu_entry_t [DEPTH-1:0] mem_q;
    alu_entry_t [DEPTH-1:0] mem_d;

    always_comb begin
        mem_d = mem_q;
        if (wr_en) begin
            mem_d[wr_addr] = wr_data;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/alu_result_fifo.sv
// First-word-fall-through buffer between the ALU and a stallable consumer;
// tags each result with a zero flag and counts carry-out events.
module alu_result_fifo
    import alu_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [ALU_W-1:0]       in_result,
    input  logic                   in_carry,
    input  logic [2:0]             in_sel,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [ALU_W-1:0]       out_result,
    output logic                   out_carry,
    output logic                   out_zero,
    output logic [2:0]             out_sel,
    output logic [$clog2(DEPTH):0] count,
    output logic [CNT_W-1:0]       carry_cnt
);

    localparam int unsigned PTR_W    = $clog2(DEPTH);
    localparam int unsigned OCC_W    = PTR_W + 1;
    localparam logic [OCC_W-1:0] FULL_LVL = OCC_W'(DEPTH);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] carry_cnt_q, carry_cnt_d;

    logic       push;
    logic       pop;
    alu_entry_t wr_entry;
    alu_entry_t head;

    // Flow control depends only on registered occupancy: a pop never frees a
    // slot for a push in the same cycle.
    assign in_ready  = (count_q != FULL_LVL);
    assign out_valid = (count_q != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    always_comb begin
        wr_entry        = '0;
        wr_entry.sel    = in_sel;
        wr_entry.carry  = in_carry;
        wr_entry.zero   = (in_result == '0);
        wr_entry.result = in_result;
    end

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        carry_cnt_d = carry_cnt_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (push && !pop) begin
            count_d = count_q + OCC_W'(1);
        end else if (pop && !push) begin
            count_d = count_q - OCC_W'(1);
        end
        if (push && in_carry && (carry_cnt_q != '1)) begin
            carry_cnt_d = carry_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            carry_cnt_q <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            carry_cnt_q <= carry_cnt_d;
        end
    end

    alu_fifo_mem #(
        .DEPTH (DEPTH)
    ) u_mem (
        .clk     (clk),
        .wr_en   (push),
        .wr_addr (wr_ptr_q),
        .wr_data (wr_entry),
        .rd_addr (rd_ptr_q),
        .rd_data (head)
    );

    // Head fields are forced to zero while empty so stale storage never leaks.
    always_comb begin
        out_result = '0;
        out_carry  = 1'b0;
        out_zero   = 1'b0;
        out_sel    = '0;
        if (out_valid) begin
            out_result = head.result;
            out_carry  = head.carry;
            out_zero   = head.zero;
            out_sel    = head.sel;
        end
    end

    assign count     = count_q;
    assign carry_cnt = carry_cnt_q;

endmodule

// File: tb/tb_alu_result_fifo.sv
// Scoreboard bench for alu_result_fifo: directed pushes queue expected heads,
// a negedge monitor compares every popped head in order.
module tb_alu_result_fifo;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned CNT_W = 2;

    typedef struct packed {
        logic [2:0] sel;
        logic       carry;
        logic       zero;
        logic [3:0] result;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_result;
    logic       in_carry;
    logic [2:0] in_sel;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_result;
    logic       out_carry;
    logic       out_zero;
    logic [2:0] out_sel;
    logic [2:0] count;
    logic [CNT_W-1:0] carry_cnt;

    int   n_total;
    int   n_pass;
    exp_t sb[$];

    alu_result_fifo #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_result  (in_result),
        .in_carry   (in_carry),
        .in_sel     (in_sel),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_carry  (out_carry),
        .out_zero   (out_zero),
        .out_sel    (out_sel),
        .count      (count),
        .carry_cnt  (carry_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Compare the head against the oldest expected entry whenever a pop is
    // about to happen at the coming rising edge.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_pop: got %0h expected none",
                         {out_sel, out_carry, out_zero, out_result});
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("head_entry", 32'({out_sel, out_carry, out_zero, out_result}), 32'(e));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [3:0] res, input logic c, input logic [2:0] sel,
                        input bit accepted);
        exp_t e;
        in_valid  = 1'b1;
        in_result = res;
        in_carry  = c;
        in_sel    = sel;
        step();
        in_valid  = 1'b0;
        if (accepted) begin
            e.sel = sel; e.carry = c; e.zero = (res == 4'd0); e.result = res;
            sb.push_back(e);
        end
    endtask

    task automatic drain(input int n);
        out_ready = 1'b1;
        repeat (n) step();
        out_ready = 1'b0;
    endtask

    initial begin
        n_total   = 0;
        n_pass    = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_result = 4'd0;
        in_carry  = 1'b0;
        in_sel    = 3'd0;
        out_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
        step();

        // Reset then idle
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_carry_cnt", 32'(carry_cnt), 32'd0);
        chk("rst_out_fields", 32'({out_sel, out_carry, out_zero, out_result}), 32'd0);

        // Single entry: ADD 0101+0011 = 1000
        push(4'b1000, 1'b0, 3'b000, 1'b1);
        chk("single_valid", 32'(out_valid), 32'd1);
        chk("single_result", 32'(out_result), 32'b1000);
        chk("single_zero", 32'(out_zero), 32'd0);
        chk("single_count", 32'(count), 32'd1);
        drain(1);
        chk("single_count_after", 32'(count), 32'd0);
        chk("single_empty_fields", 32'({out_sel, out_carry, out_zero, out_result}), 32'd0);

        // Fill to full, fifth push ignored
        push(4'b0010, 1'b0, 3'b001, 1'b1);
        push(4'b0001, 1'b0, 3'b010, 1'b1);
        push(4'b0110, 1'b0, 3'b100, 1'b1);
        push(4'b1010, 1'b0, 3'b110, 1'b1);
        chk("full_in_ready", 32'(in_ready), 32'd0);
        chk("full_count", 32'(count), 32'd4);
        push(4'b1111, 1'b1, 3'b111, 1'b0);
        chk("full_count_hold", 32'(count), 32'd4);
        chk("full_carry_cnt", 32'(carry_cnt), 32'd0);
        drain(4);
        chk("full_drained", 32'(count), 32'd0);

        // Simultaneous push and pop at count=2
        push(4'b0011, 1'b0, 3'b000, 1'b1);
        push(4'b0100, 1'b0, 3'b011, 1'b1);
        chk("sim_count_pre", 32'(count), 32'd2);
        out_ready = 1'b1;
        push(4'b0101, 1'b0, 3'b101, 1'b1);
        out_ready = 1'b0;
        chk("sim_count_hold", 32'(count), 32'd2);
        chk("sim_head", 32'(out_result), 32'b0100);
        drain(2);
        chk("sim_drained", 32'(count), 32'd0);

        // Zero flag and saturating carry counter
        repeat (3) push(4'b0000, 1'b1, 3'b001, 1'b1);
        chk("carry_cnt_3", 32'(carry_cnt), 32'd3);
        chk("zero_head", 32'(out_zero), 32'd1);
        drain(3);
        push(4'b0000, 1'b1, 3'b001, 1'b1);
        chk("carry_cnt_sat", 32'(carry_cnt), 32'd3);
        drain(1);

        // Reset mid-stream with a concurrent push
        push(4'b0111, 1'b0, 3'b010, 1'b1);
        push(4'b1001, 1'b1, 3'b011, 1'b1);
        push(4'b1100, 1'b0, 3'b100, 1'b1);
        chk("mid_count_pre", 32'(count), 32'd3);
        rst       = 1'b1;
        in_valid  = 1'b1;
        in_result = 4'b1110;
        in_carry  = 1'b1;
        step();
        rst      = 1'b0;
        in_valid = 1'b0;
        sb.delete();
        chk("mid_count", 32'(count), 32'd0);
        chk("mid_out_valid", 32'(out_valid), 32'd0);
        chk("mid_carry_cnt", 32'(carry_cnt), 32'd0);
        chk("mid_in_ready", 32'(in_ready), 32'd1);

        // Post-reset pointers restart cleanly
        push(4'b0110, 1'b0, 3'b110, 1'b1);
        chk("post_rst_result", 32'(out_result), 32'b0110);
        drain(1);

        step();
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
